// File: rtl/devil_active_engine.sv
// devil_active_engine: ACE master that runs the devil controller's active line
// read (ADL) and line write (ADT) commands as 4-beat INCR bursts.
module devil_active_engine #(
   parameter int         C_ACE_DATA_WIDTH = 128,
   parameter int         C_ACE_ADDR_WIDTH = 44,
   parameter logic [3:0] C_FUNC_ADL       = 4'h1,
   parameter logic [3:0] C_FUNC_ADT       = 4'h2
) (
   input  logic                            ace_aclk,
   input  logic                            ace_areset,
   input  logic                            i_trigger_active,
   input  logic [3:0]                      i_active_func,
   input  logic [C_ACE_ADDR_WIDTH-1:0]     i_araddr,
   input  logic [C_ACE_ADDR_WIDTH-1:0]     i_awaddr,
   input  logic [3:0]                      i_arsnoop,
   input  logic [2:0]                      i_awsnoop,
   input  logic [1:0]                      i_ardomain,
   input  logic [4*C_ACE_DATA_WIDTH-1:0]   i_cache_line,
   output logic                            o_end_active,
   output logic [4*C_ACE_DATA_WIDTH-1:0]   o_cache_line,
   output logic                            o_busy,
   output logic                            o_error,
   output logic [C_ACE_ADDR_WIDTH-1:0]     o_araddr,
   output logic [7:0]                      o_arlen,
   output logic [2:0]                      o_arsize,
   output logic [1:0]                      o_arburst,
   output logic [3:0]                      o_arsnoop,
   output logic [1:0]                      o_ardomain,
   output logic [1:0]                      o_arbar,
   output logic                            o_arvalid,
   input  logic                            i_arready,
   input  logic [C_ACE_DATA_WIDTH-1:0]     i_rdata,
   input  logic [3:0]                      i_rresp,
   input  logic                            i_rlast,
   input  logic                            i_rvalid,
   output logic                            o_rready,
   output logic                            o_rack,
   output logic [C_ACE_ADDR_WIDTH-1:0]     o_awaddr,
   output logic [7:0]                      o_awlen,
   output logic [2:0]                      o_awsize,
   output logic [1:0]                      o_awburst,
   output logic [2:0]                      o_awsnoop,
   output logic [1:0]                      o_awdomain,
   output logic [1:0]                      o_awbar,
   output logic                            o_awvalid,
   input  logic                            i_awready,
   output logic [C_ACE_DATA_WIDTH-1:0]     o_wdata,
   output logic [C_ACE_DATA_WIDTH/8-1:0]   o_wstrb,
   output logic                            o_wlast,
   output logic                            o_wvalid,
   input  logic                            i_wready,
   input  logic [1:0]                      i_bresp,
   input  logic                            i_bvalid,
   output logic                            o_bready,
   output logic                            o_wack
);

   localparam int DW     = C_ACE_DATA_WIDTH;
   localparam int LINE_W = 4 * DW;
   localparam int STRB_W = DW / 8;

   typedef enum logic [3:0] {
      S_IDLE, S_AR, S_R, S_RACK, S_AW, S_W, S_B, S_WACK, S_DONE
   } state_t;

   state_t                      state_q, state_d;
   logic [1:0]                  beat_q, beat_d;
   logic                        armed_q, armed_d;
   logic                        error_q, error_d;
   logic [C_ACE_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [3:0]                  arsnoop_q, arsnoop_d;
   logic [2:0]                  awsnoop_q, awsnoop_d;
   logic [1:0]                  domain_q, domain_d;
   logic [LINE_W-1:0]           wline_q, wline_d;
   logic [LINE_W-1:0]           rline_q, rline_d;
   logic [DW-1:0]               wbeat_data [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_wbeat
         assign wbeat_data[gi] = wline_q[gi*DW +: DW];
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      armed_d   = armed_q;
      error_d   = error_q;
      addr_d    = addr_q;
      arsnoop_d = arsnoop_q;
      awsnoop_d = awsnoop_q;
      domain_d  = domain_q;
      wline_d   = wline_q;
      rline_d   = rline_q;

      // A trigger still held from the previous command must not re-arm.
      if (!i_trigger_active) begin
         armed_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (i_trigger_active && armed_q) begin
               armed_d   = 1'b0;
               error_d   = 1'b0;
               beat_d    = 2'd0;
               arsnoop_d = i_arsnoop;
               awsnoop_d = i_awsnoop;
               domain_d  = i_ardomain;
               if (i_active_func == C_FUNC_ADL) begin
                  addr_d  = {i_araddr[C_ACE_ADDR_WIDTH-1:6], 6'b0};
                  state_d = S_AR;
               end else if (i_active_func == C_FUNC_ADT) begin
                  addr_d  = {i_awaddr[C_ACE_ADDR_WIDTH-1:6], 6'b0};
                  wline_d = i_cache_line;
                  state_d = S_AW;
               end else begin
                  error_d = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_AR: if (i_arready) state_d = S_R;
         S_R: begin
            if (i_rvalid) begin
               rline_d[int'(beat_q)*DW +: DW] = i_rdata;
               if (i_rresp[1] || (i_rlast != (beat_q == 2'd3))) begin
                  error_d = 1'b1;
               end
               if (beat_q == 2'd3) state_d = S_RACK;
               else                beat_d  = beat_q + 2'd1;
            end
         end
         S_RACK: state_d = S_DONE;
         S_AW: begin
            if (i_awready) begin
               beat_d  = 2'd0;
               state_d = S_W;
            end
         end
         S_W: begin
            if (i_wready) begin
               if (beat_q == 2'd3) state_d = S_B;
               else                beat_d  = beat_q + 2'd1;
            end
         end
         S_B: begin
            if (i_bvalid) begin
               if (i_bresp[1]) error_d = 1'b1;
               state_d = S_WACK;
            end
         end
         S_WACK:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ace_aclk or posedge ace_areset) begin
      if (ace_areset) begin
         state_q   <= S_IDLE;
         beat_q    <= 2'd0;
         armed_q   <= 1'b1;
         error_q   <= 1'b0;
         addr_q    <= '0;
         arsnoop_q <= '0;
         awsnoop_q <= '0;
         domain_q  <= '0;
         wline_q   <= '0;
         rline_q   <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         armed_q   <= armed_d;
         error_q   <= error_d;
         addr_q    <= addr_d;
         arsnoop_q <= arsnoop_d;
         awsnoop_q <= awsnoop_d;
         domain_q  <= domain_d;
         wline_q   <= wline_d;
         rline_q   <= rline_d;
      end
   end

   // Static burst fields read as zero whenever their channel is idle.
   assign o_arvalid    = (state_q == S_AR);
   assign o_araddr     = addr_q;
   assign o_arlen      = o_arvalid ? 8'd3 : 8'd0;
   assign o_arsize     = o_arvalid ? 3'b100 : 3'b000;
   assign o_arburst    = o_arvalid ? 2'b01 : 2'b00;
   assign o_arsnoop    = arsnoop_q;
   assign o_ardomain   = domain_q;
   assign o_arbar      = 2'b00;
   assign o_rready     = (state_q == S_R);
   assign o_rack       = (state_q == S_RACK);

   assign o_awvalid    = (state_q == S_AW);
   assign o_awaddr     = addr_q;
   assign o_awlen      = o_awvalid ? 8'd3 : 8'd0;
   assign o_awsize     = o_awvalid ? 3'b100 : 3'b000;
   assign o_awburst    = o_awvalid ? 2'b01 : 2'b00;
   assign o_awsnoop    = awsnoop_q;
   assign o_awdomain   = domain_q;
   assign o_awbar      = 2'b00;
   assign o_wvalid     = (state_q == S_W);
   assign o_wdata      = o_wvalid ? wbeat_data[beat_q] : '0;
   assign o_wstrb      = o_wvalid ? {STRB_W{1'b1}} : '0;
   assign o_wlast      = o_wvalid && (beat_q == 2'd3);
   assign o_bready     = (state_q == S_B);
   assign o_wack       = (state_q == S_WACK);

   assign o_end_active = (state_q == S_DONE);
   assign o_busy       = (state_q != S_IDLE) && (state_q != S_DONE);
   assign o_error      = error_q;
   assign o_cache_line = rline_q;

endmodule

// File: tb/tb_devil_active_engine.sv
// Self-checking bench for devil_active_engine: directed table, hand-written
// reset sequence and randomized commands against a line-level reference model.
module tb_devil_active_engine;
   localparam int         DW  = 128;
   localparam int         AW  = 44;
   localparam logic [3:0] ADL = 4'h1;
   localparam logic [3:0] ADT = 4'h2;

   typedef struct {
      logic [3:0]  func;
      logic [43:0] addr;
      int          mode;      // 0 ready always, 1 toggling, 2 random
      bit          fixed;     // use the test-plan data patterns
      int          rerr_beat; // beat with rresp[1], -1 none
      int          rlast_bad; // beat with wrong rlast, -1 none
      bit          berr;
      int          hold;      // cycles trigger stays high after end
      bit          exp_error;
      int          exp_end_at; // 0 = latency not checked
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic             i_trigger_active;
   logic [3:0]       i_active_func;
   logic [AW-1:0]    i_araddr, i_awaddr;
   logic [3:0]       i_arsnoop;
   logic [2:0]       i_awsnoop;
   logic [1:0]       i_ardomain;
   logic [4*DW-1:0]  i_cache_line;
   logic             o_end_active, o_busy, o_error;
   logic [4*DW-1:0]  o_cache_line;
   logic [AW-1:0]    o_araddr, o_awaddr;
   logic [7:0]       o_arlen, o_awlen;
   logic [2:0]       o_arsize, o_awsize;
   logic [1:0]       o_arburst, o_awburst, o_ardomain, o_awdomain, o_arbar, o_awbar;
   logic [3:0]       o_arsnoop;
   logic [2:0]       o_awsnoop;
   logic             o_arvalid, i_arready, o_awvalid, i_awready;
   logic [DW-1:0]    i_rdata, o_wdata;
   logic [3:0]       i_rresp;
   logic             i_rlast, i_rvalid, o_rready, o_rack;
   logic [DW/8-1:0]  o_wstrb;
   logic             o_wlast, o_wvalid, i_wready;
   logic [1:0]       i_bresp;
   logic             i_bvalid, o_bready, o_wack;

   devil_active_engine #(
      .C_ACE_DATA_WIDTH(DW), .C_ACE_ADDR_WIDTH(AW),
      .C_FUNC_ADL(ADL), .C_FUNC_ADT(ADT)
   ) dut (
      .ace_aclk(clk), .ace_areset(rst),
      .i_trigger_active(i_trigger_active), .i_active_func(i_active_func),
      .i_araddr(i_araddr), .i_awaddr(i_awaddr), .i_arsnoop(i_arsnoop),
      .i_awsnoop(i_awsnoop), .i_ardomain(i_ardomain), .i_cache_line(i_cache_line),
      .o_end_active(o_end_active), .o_cache_line(o_cache_line), .o_busy(o_busy),
      .o_error(o_error),
      .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
      .o_arsnoop(o_arsnoop), .o_ardomain(o_ardomain), .o_arbar(o_arbar),
      .o_arvalid(o_arvalid), .i_arready(i_arready),
      .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
      .o_rready(o_rready), .o_rack(o_rack),
      .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
      .o_awsnoop(o_awsnoop), .o_awdomain(o_awdomain), .o_awbar(o_awbar),
      .o_awvalid(o_awvalid), .i_awready(i_awready),
      .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
      .i_wready(i_wready),
      .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready), .o_wack(o_wack)
   );

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [511:0] model_line = '0;  // last line the bus returned for a completed read
   vec_t        tbl [9];

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic bit rdy(input int mode, input int j);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (j % 2) == 0;
      return $urandom_range(0, 3) != 0;
   endfunction

   task automatic idle_inputs();
      i_arready = 0; i_rvalid = 0; i_rlast = 0; i_rresp = 0; i_rdata = '0;
      i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
   endtask

   // Runs one command as the bus slave; rst_wbeat >= 0 resets the DUT while W beat rst_wbeat waits.
   task automatic run_cmd(input vec_t v, input int rst_wbeat);
      logic [DW-1:0]  beats [4];
      logic [511:0]   wline;
      logic [AW-1:0]  exp_addr;
      logic [3:0]     drv_arsnoop;
      logic [2:0]     drv_awsnoop;
      logic [1:0]     drv_dom;
      logic [7:0]     cap_len;
      logic [2:0]     cap_size;
      logic [1:0]     cap_burst;
      logic [3:0]     cap_snoop;
      logic [1:0]     cap_dom;
      bit is_rd, is_wr, exp_err, end_seen, b_done, addr_bad, w_before_aw, ar_seen, aw_seen;
      int rbeat, wbeat, ar_hs, aw_hs, rack_n, wack_n, end_at, spurious;

      is_rd = (v.func == ADL);
      is_wr = (v.func == ADT);
      for (int k = 0; k < 4; k++) begin
         if (v.fixed) beats[k] = is_rd ? {16{8'(8'hA0 + k)}} : 128'(k + 1);
         else         beats[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      wline    = {beats[3], beats[2], beats[1], beats[0]};
      exp_addr = {v.addr[43:6], 6'b0};
      exp_err  = (!is_rd && !is_wr) ||
                 (is_rd && (v.rerr_beat >= 0 || v.rlast_bad >= 0)) || (is_wr && v.berr);
      drv_arsnoop = 4'($urandom);
      drv_awsnoop = 3'($urandom);
      drv_dom     = 2'($urandom);
      cap_len = 0; cap_size = 0; cap_burst = 0; cap_snoop = 0; cap_dom = 0;
      rbeat = 0; wbeat = 0; ar_hs = 0; aw_hs = 0; rack_n = 0; wack_n = 0; end_at = 0;
      end_seen = 0; b_done = 0; addr_bad = 0; w_before_aw = 0; ar_seen = 0; aw_seen = 0;

      i_active_func = v.func;
      i_araddr = v.addr;
      i_awaddr = v.addr;
      i_arsnoop = drv_arsnoop;
      i_awsnoop = drv_awsnoop;
      i_ardomain = drv_dom;
      i_cache_line = is_wr ? wline : {16{$urandom}};
      i_trigger_active = 1'b1;

      for (int j = 0; j < 200; j++) begin
         @(posedge clk); #1;
         idle_inputs();
         if (j == 0 && (is_rd || is_wr)) check("busy_after_accept", 512'(o_busy), 512'(1));
         if (o_wvalid) begin
            if (aw_hs == 0) w_before_aw = 1;
            if (rst_wbeat >= 0 && wbeat == rst_wbeat) begin
               #2 rst = 1'b1;
               #1;
               check("rst_wvalid", 512'(o_wvalid), 512'(0));
               check("rst_busy", 512'(o_busy), 512'(0));
               check("rst_cache_line", o_cache_line, 512'(0));
               model_line = '0;
               i_trigger_active = 1'b0;
               @(posedge clk); #1;
               rst = 1'b0;
               @(posedge clk); #1;
               return;
            end
            if (rdy(v.mode, j)) begin
               i_wready = 1;
               check("wdata", 512'(o_wdata), 512'(beats[wbeat]));
               check("wlast", 512'(o_wlast), 512'(wbeat == 3));
               check("wstrb", 512'(o_wstrb), 512'(16'hFFFF));
               wbeat++;
            end
         end
         if (o_arvalid) begin
            if (!ar_seen) begin
               cap_len = o_arlen; cap_size = o_arsize; cap_burst = o_arburst;
               cap_snoop = o_arsnoop; cap_dom = o_ardomain;
            end
            ar_seen = 1;
            if (o_araddr !== exp_addr) addr_bad = 1;
            if (rdy(v.mode, j)) begin i_arready = 1; ar_hs++; end
         end
         if (o_awvalid) begin
            if (!aw_seen) begin
               cap_len = o_awlen; cap_size = o_awsize; cap_burst = o_awburst;
               cap_snoop = 4'(o_awsnoop); cap_dom = o_awdomain;
            end
            aw_seen = 1;
            if (o_awaddr !== exp_addr) addr_bad = 1;
            if (rdy(v.mode, j)) begin i_awready = 1; aw_hs++; end
         end
         if (o_rready && rbeat < 4 && rdy(v.mode, j)) begin
            i_rvalid = 1;
            i_rdata  = beats[rbeat];
            i_rresp  = (rbeat == v.rerr_beat) ? 4'b0010 : 4'b0000;
            i_rlast  = (rbeat == 3) ^ (rbeat == v.rlast_bad);
            rbeat++;
         end
         if (o_bready && !b_done && rdy(v.mode, j)) begin
            i_bvalid = 1;
            i_bresp  = v.berr ? 2'b10 : 2'b00;
            b_done   = 1;
         end
         if (o_rack) rack_n++;
         if (o_wack) wack_n++;
         if (o_end_active) begin
            end_seen = 1;
            end_at   = j + 1;
            check("error_at_end", 512'(o_error), 512'(exp_err));
            check("busy_at_end", 512'(o_busy), 512'(0));
            break;
         end
      end
      check("end_seen", 512'(end_seen), 512'(1));
      if (v.exp_end_at != 0) check("end_latency", 512'(end_at), 512'(v.exp_end_at));
      check("table_error", 512'(exp_err), 512'(v.exp_error));

      if (is_rd) begin
         model_line = wline;
         check("ar_handshakes", 512'(ar_hs), 512'(1));
         check("r_beats", 512'(rbeat), 512'(4));
         check("rack_count", 512'(rack_n), 512'(1));
         check("no_awvalid_on_read", 512'(aw_seen), 512'(0));
      end
      if (is_wr) begin
         check("aw_handshakes", 512'(aw_hs), 512'(1));
         check("w_handshakes", 512'(wbeat), 512'(4));
         check("wack_count", 512'(wack_n), 512'(1));
         check("w_before_aw", 512'(w_before_aw), 512'(0));
         check("no_arvalid_on_write", 512'(ar_seen), 512'(0));
      end
      if (is_rd || is_wr) begin
         check("addr_aligned_stable", 512'(addr_bad), 512'(0));
         check("len", 512'(cap_len), 512'(3));
         check("size_burst", 512'({cap_size, cap_burst}), 512'({3'b100, 2'b01}));
         check("snoop", 512'(cap_snoop), is_rd ? 512'(drv_arsnoop) : 512'(drv_awsnoop));
         check("domain", 512'(cap_dom), 512'(drv_dom));
      end else begin
         check("no_valid_on_illegal", 512'(ar_seen | aw_seen), 512'(0));
      end

      spurious = 0;
      for (int k = 0; k < v.hold; k++) begin
         @(posedge clk); #1;
         idle_inputs();
         if (o_arvalid || o_awvalid || o_busy || o_end_active) spurious++;
      end
      check("held_trigger_quiet", 512'(spurious), 512'(0));
      check("cache_line", o_cache_line, model_line);
      i_trigger_active = 1'b0;
      @(posedge clk); #1;
      $display("cmd func=%h addr=%h err=%0d end_at=%0d", v.func, v.addr, exp_err, end_at);
   endtask

   initial begin
      vec_t rv;
      rst = 1'b1;
      i_trigger_active = 0; i_active_func = 0; i_araddr = 0; i_awaddr = 0;
      i_arsnoop = 0; i_awsnoop = 0; i_ardomain = 0; i_cache_line = '0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 512'(o_busy), 512'(0));
      check("reset_valids", 512'({o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready}), 512'(0));
      check("reset_end_err", 512'({o_end_active, o_error, o_rack, o_wack}), 512'(0));
      check("reset_static", 512'({o_arlen, o_awlen, o_wstrb, o_arsize}), 512'(0));
      check("reset_cache_line", o_cache_line, 512'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      //            func  addr                  mode fix rerr rlast berr hold err end
      tbl[0] = '{ADL,   44'h0_1234_5678,      0,   1,  -1,  -1,   0,   1,   0,  7};
      tbl[1] = '{ADT,   44'h80,               1,   1,  -1,  -1,   0,   1,   0,  0};
      tbl[2] = '{ADL,   44'h0_0000_1FC0,      0,   0,   2,  -1,   0,   1,   1,  7};
      tbl[3] = '{ADL,   44'hABC_DEF0_1234,    0,   0,  -1,   3,   0,   1,   1,  7};
      tbl[4] = '{ADL,   44'h777,              2,   0,  -1,   1,   0,   1,   1,  0};
      tbl[5] = '{ADT,   44'h1_0000_003F,      0,   0,  -1,  -1,   1,   1,   1,  8};
      tbl[6] = '{4'hF,  44'h40,               0,   0,  -1,  -1,   0,   1,   1,  1};
      tbl[7] = '{ADT,   44'h5_5555_5555,      0,   0,  -1,  -1,   0,   1,   0,  8};
      tbl[8] = '{ADL,   44'h0_0000_0100,      0,   0,  -1,  -1,   0,   5,   0,  7};
      for (int i = 0; i < 9; i++) run_cmd(tbl[i], -1);
      check("rl_araddr_planned", 512'(o_araddr), 512'(44'h0_0000_0100));

      // Reset while W beat 2 is pending, then a normal read afterwards.
      rv = '{ADT, 44'h2000, 0, 0, -1, -1, 0, 1, 0, 0};
      run_cmd(rv, 2);
      rv = '{ADL, 44'h3_0000_0040, 0, 0, -1, -1, 0, 1, 0, 7};
      run_cmd(rv, -1);

      for (int i = 0; i < 30; i++) begin
         int r;
         r = $urandom_range(0, 9);
         rv.func = (r < 5) ? ADL : (r < 9) ? ADT : 4'(4'h3 + $urandom_range(0, 12));
         rv.addr = {12'($urandom), 32'($urandom)};
         rv.mode = 2;
         rv.fixed = 0;
         rv.rerr_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
         rv.rlast_bad = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
         rv.berr = ($urandom_range(0, 3) == 0);
         rv.hold = 1 + int'($urandom_range(0, 2));
         rv.exp_error = (rv.func != ADL && rv.func != ADT) ||
                        (rv.func == ADL && (rv.rerr_beat >= 0 || rv.rlast_bad >= 0)) ||
                        (rv.func == ADT && rv.berr);
         rv.exp_end_at = 0;
         run_cmd(rv, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/devil_active_engine.md
# devil_active_engine

Bus-side executor for the devil controller's active commands. It is the ACE master port of the active devil: it accepts a line-sized read (ADL) or write (ADT) command from the devil controller, runs the matching 4-beat ACE transaction on the AR/R or AW/W/B channels, and returns completion plus the read cache line. It sits between the controller's `o_trigger_active` / `o_controller_signals` / `o_cache_line_active_devil` outputs and the FPGA ACE master interface.

## Interface
- C_ACE_DATA_WIDTH, 128, data beat width; a cache line is 4 beats (512 bits)
- C_ACE_ADDR_WIDTH, 44, ACE address width
- ace_aclk  in  1  clock
- ace_areset  in  1  asynchronous, active-high reset
- i_trigger_active  in  1  command request, level; held by the controller until after completion
- i_active_func  in  4  `ADL` = read, `ADT` = write (encodings from devil_in_fpga.vh); any other value is illegal
- i_araddr / i_awaddr  in  C_ACE_ADDR_WIDTH  command addresses
- i_arsnoop  in  4, i_awsnoop  in  3, i_ardomain  in  2  snoop type and shareability domain
- i_cache_line  in  4*C_ACE_DATA_WIDTH  write data; beat k = bits [128k+127:128k]
- o_end_active  out  1  single-cycle completion pulse
- o_cache_line  out  4*C_ACE_DATA_WIDTH  last read line; holds its value until the next read
- o_busy  out  1  high from command accept until o_end_active
- o_error  out  1  sticky per command; valid with o_end_active
- AR: o_araddr, o_arlen[7:0], o_arsize[2:0], o_arburst[1:0], o_arsnoop[3:0], o_ardomain[1:0], o_arbar[1:0], o_arvalid out; i_arready in
- R: i_rdata[127:0], i_rresp[3:0], i_rlast, i_rvalid in; o_rready, o_rack out
- AW: o_awaddr, o_awlen, o_awsize, o_awburst, o_awsnoop[2:0], o_awdomain[1:0], o_awbar, o_awvalid out; i_awready in
- W: o_wdata[127:0], o_wstrb[15:0], o_wlast, o_wvalid out; i_wready in
- B: i_bresp[1:0], i_bvalid in; o_bready, o_wack out

## Operation
- Reset values: every output 0, state IDLE, armed = 1.
- Static fields: len = 3, size = 3'b100, burst = INCR (2'b01), bar = 0, wstrb = 16'hFFFF. Addresses are line-aligned by forcing [5:0] = 0. Command fields are latched at accept.
- Arming: a command is accepted in IDLE when i_trigger_active = 1 and armed = 1. Accept clears armed. armed is set again only when i_trigger_active is sampled 0. Because the controller holds the trigger for one or more cycles after completion, a held trigger never starts a second command.
- State machine: IDLE -> (ADL) AR -> R -> RACK -> DONE; IDLE -> (ADT) AW -> W -> B -> WACK -> DONE; IDLE -> (illegal func) DONE with o_error = 1 and no bus activity.
- AR/AW: valid is held until the ready handshake. Address and control must not change while valid is high.
- R: o_rready = 1 throughout R. Beat counter 0..3; beat k is written to o_cache_line slice k.
  - rresp[1] = 1 on any beat sets o_error.
  - rlast on a beat other than 3, or missing on beat 3, sets o_error. The state still leaves R after beat 3.
- W: beats 0..3 from the latched i_cache_line. o_wlast = 1 on beat 3. The counter advances only on wvalid & wready. o_wvalid is held between beats (no bubbles required).
- B: o_bready = 1. bresp[1] = 1 sets o_error.
- RACK/WACK: o_rack or o_wack high for exactly one cycle.
- DONE: o_end_active = 1 for one cycle, then IDLE. o_busy drops in the same cycle o_end_active rises.
- o_error is cleared at the next accept.
- Reset mid-transaction: all valids, acks and o_busy drop asynchronously. A partially written o_cache_line is cleared. There is no recovery handshake; the system resets the bus at the same time.

## Timing
- Accept at edge N. o_arvalid or o_awvalid is high from N+1.
- AW handshake: o_wvalid rises in the cycle after the AW handshake. W never precedes AW.
- Best case with ready always high:
  - Read: AR handshake N+1, R beats N+2..N+5, rack N+6, end N+7.
  - Write: AW N+1, W N+2..N+5, B at N+6 earliest, wack in the cycle after the B handshake, end one cycle after wack.
- Illegal func: o_end_active at N+1.
- o_cache_line is stable from the cycle of the final R handshake plus one, and no later than o_end_active.

## Test plan
- ADL, araddr = 0x0_1234_5678, ready and valid always high, rdata beats 0xA0..0xA3 replicated -> o_araddr = 0x0_1234_5640, arlen = 3; o_cache_line = {A3,A2,A1,A0}; rack at N+6, end at N+7, o_error = 0.
- ADT, awaddr = 0x80, i_cache_line = 512'h1..4 beats, wready toggling 1/0 -> exactly 4 W handshakes in order, wlast only on the 4th, one wack, then one end pulse.
- ADL with rresp = 2'b10 on beat 2 -> o_error = 1 at end, all 4 beats still consumed, rack still issued.
- Trigger held high for 5 cycles after end -> no second AR; drop trigger for 1 cycle then raise -> a new command is accepted.
- i_active_func = 4'hF -> end at N+1 with o_error = 1, and no arvalid/awvalid ever.
- Assert ace_areset during W beat 2 -> o_wvalid, o_busy and o_cache_line are 0 in the same cycle; after release, an ADL completes normally.
